// File: rtl/uv_sched_pkg.sv
// uv_sched_pkg: scheduler state encoding and the byte layout of the
// diffusion-error buses shared by the scheduler and its error RAM.
package uv_sched_pkg;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_START = 3'd2,
        S_BUSY  = 3'd3,
        S_STORE = 3'd4,
        S_OUT   = 3'd5
    } state_t;

    // Two chroma planes (U, V), signed 8-bit error bytes.
    localparam int NUM_CH = 2;
    localparam int EB     = 8;

    // Engine error bytes per plane: e[c][0..2].
    localparam int ERR_K0 = 0;
    localparam int ERR_K1 = 1;
    localparam int ERR_K2 = 2;

    // Left/top error bytes per plane: l[c][0..1], t[c][0..1].
    localparam int LT_J0 = 0;
    localparam int LT_J1 = 1;

    // Bit offset of e[c][k] inside the 48-bit engine error bus.
    function automatic int derr_off(input int c, input int k);
        return 24 * c + 8 * k;
    endfunction

    // Bit offset of l[c][j] / t[c][j] inside a 32-bit left/top word.
    function automatic int lt_off(input int c, input int j);
        return 16 * c + 8 * j;
    endfunction

endpackage

// File: rtl/uv_derr_ram.sv
// uv_derr_ram: simple dual-port top-error store, one word per macroblock
// column. Registered read; a read colliding with a write returns old data.
module uv_derr_ram #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10,
    parameter int DW    = 32
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [DEPTH];

    // Write port: one word per STORE cycle.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read port: registered, sees the array before any same-cycle write.
    always_ff @(posedge clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/uv_recon_sched.sv
// uv_recon_sched: raster-order macroblock scheduler for the chroma
// reconstruction engine. Fetches each macroblock, starts the engine,
// stores its left/top diffusion errors and presents the result downstream.
// Build option: define UV_SCHED_DERR_EN to instantiate the error storage;
// without it the left/top error buses read as zero and timing is unchanged.
//
// Handshakes:
//   in_req/in_valid   : in_req is held until in_valid is seen; the data
//                       source holds in_valid (and its data) until in_req drops.
//   out_valid/out_ready: a macroblock transfers on a cycle where both are
//                       high; out_valid, out_x, out_y and out_last hold steady
//                       while out_ready is low.
module uv_recon_sched
    import uv_sched_pkg::*;
#(
    parameter int MAX_MBW = 1024,
    parameter int AW      = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          frame_start,
    input  logic [AW-1:0] mb_w,
    input  logic [AW-1:0] mb_h,
    output logic          busy,
    output logic          frame_done,
    output logic          in_req,
    input  logic          in_valid,
    output logic          eng_start,
    output logic [AW-1:0] eng_x,
    output logic [AW-1:0] eng_y,
    input  logic          eng_done,
    input  logic [47:0]   eng_derr,
    output logic [31:0]   eng_left_derr,
    output logic [31:0]   eng_top_derr,
    input  logic          eng_top_derr_en,
    input  logic [AW-1:0] eng_top_derr_addr,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [AW-1:0] out_x,
    output logic [AW-1:0] out_y,
    output logic          out_last,
    output state_t        dbg_state
);

    state_t        state;
    logic [AW-1:0] w_q;
    logic [AW-1:0] h_q;
    logic [AW:0]   x_inc;
    logic          row_end;
    logic          is_last;
    logic          frame_acc;
    logic          mb_acc;

    assign x_inc     = {1'b0, eng_x} + {{AW{1'b0}}, 1'b1};
    assign row_end   = (x_inc >= {1'b0, w_q});
    assign is_last   = (eng_x == w_q - AW'(1)) && (eng_y == h_q - AW'(1));
    assign frame_acc = (state == S_IDLE) && frame_start;
    assign mb_acc    = (state == S_OUT) && out_ready;
    assign dbg_state = state;

    // Control FSM with all handshake/status outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            in_req     <= 1'b0;
            eng_start  <= 1'b0;
            out_valid  <= 1'b0;
            out_last   <= 1'b0;
            eng_x      <= '0;
            eng_y      <= '0;
            out_x      <= '0;
            out_y      <= '0;
            w_q        <= '0;
            h_q        <= '0;
        end else begin
            frame_done <= 1'b0;
            eng_start  <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (frame_start) begin
                        w_q   <= mb_w;
                        h_q   <= mb_h;
                        eng_x <= '0;
                        eng_y <= '0;
                        if (mb_w == '0 || mb_h == '0) begin
                            // Empty frame: report completion without going busy.
                            frame_done <= 1'b1;
                        end else begin
                            busy   <= 1'b1;
                            in_req <= 1'b1;
                            state  <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (in_valid) begin
                        in_req    <= 1'b0;
                        eng_start <= 1'b1;
                        state     <= S_START;
                    end
                end
                S_START: begin
                    state <= S_BUSY;
                end
                S_BUSY: begin
                    if (eng_done) begin
                        state <= S_STORE;
                    end
                end
                S_STORE: begin
                    out_valid <= 1'b1;
                    out_x     <= eng_x;
                    out_y     <= eng_y;
                    out_last  <= is_last;
                    state     <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_last  <= 1'b0;
                        if (is_last) begin
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                            eng_x      <= '0;
                            eng_y      <= '0;
                            state      <= S_IDLE;
                        end else begin
                            if (row_end) begin
                                eng_x <= '0;
                                eng_y <= eng_y + AW'(1);
                            end else begin
                                eng_x <= eng_x + AW'(1);
                            end
                            in_req <= 1'b1;
                            state  <= S_REQ;
                        end
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef UV_SCHED_DERR_EN
    logic [31:0] left_q;
    logic [31:0] left_nxt;
    logic [31:0] top_wdata;
    logic [31:0] ram_rdata;
    logic        row0_q;

    // Per-plane error propagation: l1 = (3*e2)>>>2, t1 = e2 - l1, all wrapping.
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
        logic signed [EB-1:0] e0;
        logic signed [EB-1:0] e1;
        logic signed [EB-1:0] e2;
        logic signed [EB-1:0] l1;
        logic signed [9:0]    prod;
        logic signed [9:0]    shr;

        assign e0   = eng_derr[derr_off(c, ERR_K0) +: EB];
        assign e1   = eng_derr[derr_off(c, ERR_K1) +: EB];
        assign e2   = eng_derr[derr_off(c, ERR_K2) +: EB];
        assign prod = $signed({{2{e2[EB-1]}}, e2}) * 10'sd3;
        assign shr  = prod >>> 2;
        assign l1   = shr[EB-1:0];

        assign left_nxt[lt_off(c, LT_J0) +: EB]  = e0;
        assign left_nxt[lt_off(c, LT_J1) +: EB]  = l1;
        assign top_wdata[lt_off(c, LT_J0) +: EB] = e1;
        assign top_wdata[lt_off(c, LT_J1) +: EB] = e2 - l1;
    end

    // Left errors: cleared at frame start and at each row wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            left_q <= '0;
        end else if (frame_acc || (mb_acc && row_end)) begin
            left_q <= '0;
        end else if (state == S_STORE) begin
            left_q <= left_nxt;
        end
    end

    // Row-0 mask tracks the row at read time so stale RAM never leaks out.
    always_ff @(posedge clk) begin
        if (rst) begin
            row0_q <= 1'b1;
        end else if (eng_top_derr_en) begin
            row0_q <= (eng_y == '0);
        end
    end

    uv_derr_ram #(
        .DEPTH(MAX_MBW),
        .AW   (AW),
        .DW   (32)
    ) u_ram (
        .clk  (clk),
        .we   (state == S_STORE),
        .waddr(eng_x),
        .wdata(top_wdata),
        .re   (eng_top_derr_en),
        .raddr(eng_top_derr_addr),
        .rdata(ram_rdata)
    );

    assign eng_left_derr = left_q;
    assign eng_top_derr  = row0_q ? '0 : ram_rdata;
`else
    logic derr_unused;

    assign derr_unused   = ^{eng_derr, eng_top_derr_en, eng_top_derr_addr,
                             frame_acc, mb_acc, row_end, MAX_MBW > 0};
    assign eng_left_derr = '0;
    assign eng_top_derr  = '0;
`endif

endmodule

// File: tb/tb_uv_recon_sched.sv
// tb_uv_recon_sched: directed bench for the macroblock scheduler.
`timescale 1ns/1ps
module tb_uv_recon_sched;
  import uv_sched_pkg::*;

  localparam int AW = 10;
`ifdef UV_SCHED_DERR_EN
  localparam bit DERR_EN = 1'b1;
`else
  localparam bit DERR_EN = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          frame_start;
  logic [AW-1:0] mb_w;
  logic [AW-1:0] mb_h;
  logic          busy;
  logic          frame_done;
  logic          in_req;
  logic          in_valid;
  logic          eng_start;
  logic [AW-1:0] eng_x;
  logic [AW-1:0] eng_y;
  logic          eng_done;
  logic [47:0]   eng_derr;
  logic [31:0]   eng_left_derr;
  logic [31:0]   eng_top_derr;
  logic          eng_top_derr_en;
  logic [AW-1:0] eng_top_derr_addr;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_x;
  logic [AW-1:0] out_y;
  logic          out_last;
  state_t        dbg_state;

  int n_cmp = 0;
  int n_bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;

  uv_recon_sched #(.MAX_MBW(1024), .AW(AW)) dut (
    .clk              (clk),
    .rst              (rst),
    .frame_start      (frame_start),
    .mb_w             (mb_w),
    .mb_h             (mb_h),
    .busy             (busy),
    .frame_done       (frame_done),
    .in_req           (in_req),
    .in_valid         (in_valid),
    .eng_start        (eng_start),
    .eng_x            (eng_x),
    .eng_y            (eng_y),
    .eng_done         (eng_done),
    .eng_derr         (eng_derr),
    .eng_left_derr    (eng_left_derr),
    .eng_top_derr     (eng_top_derr),
    .eng_top_derr_en  (eng_top_derr_en),
    .eng_top_derr_addr(eng_top_derr_addr),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_x            (out_x),
    .out_y            (out_y),
    .out_last         (out_last),
    .dbg_state        (dbg_state)
  );

  // clock / event counters
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
    if (frame_done === 1'b1) done_cnt <= done_cnt + 1;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // reference model of the error update
  function automatic logic [47:0] pk(input int a0, input int a1, input int a2,
                                     input int b0, input int b1, input int b2);
    return {8'(b2), 8'(b1), 8'(b0), 8'(a2), 8'(a1), 8'(a0)};
  endfunction

  function automatic logic [7:0] l1_of(input logic [7:0] e2);
    int p;
    int q;
    p = 3 * int'($signed(e2));
    if (p >= 0) q = p / 4;
    else q = -((-p + 3) / 4);
    return q[7:0];
  endfunction

  function automatic logic [31:0] left_model(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      r[16*c +: 8]     = d[24*c +: 8];
      r[16*c + 8 +: 8] = l1_of(d[24*c + 16 +: 8]);
    end
    return DERR_EN ? r : 32'd0;
  endfunction

  function automatic logic [31:0] top_model(input logic [47:0] d);
    logic [31:0] r;
    r = '0;
    for (int c = 0; c < 2; c++) begin
      r[16*c +: 8]     = d[24*c + 8 +: 8];
      r[16*c + 8 +: 8] = d[24*c + 16 +: 8] - l1_of(d[24*c + 16 +: 8]);
    end
    return DERR_EN ? r : 32'd0;
  endfunction

  // driver: one macroblock from start to presentation (and optional stall)
  task automatic run_mb(input string nm, input int gap, input logic [AW-1:0] ex,
                        input logic [AW-1:0] ey, input logic [47:0] derr,
                        input logic [31:0] exp_left, input logic [AW-1:0] rd_addr,
                        input logic [31:0] exp_top, input logic exp_last,
                        input int bp, input bit poke);
    int waited;
    bit seen;
    waited = 0;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      waited++;
      if (eng_start === 1'b1) seen = 1'b1;
    end
    check({nm, "_start_seen"}, 64'(seen), 64'd1);
    check({nm, "_start_gap"}, 64'(waited), 64'(gap));
    check({nm, "_eng_x"}, 64'(eng_x), 64'(ex));
    check({nm, "_eng_y"}, 64'(eng_y), 64'(ey));
    check({nm, "_req_drop"}, 64'(in_req), 64'd0);
    check({nm, "_busy"}, 64'(busy), 64'd1);
    @(negedge clk);
    check({nm, "_left"}, 64'(eng_left_derr), 64'(exp_left));
    eng_top_derr_en = 1'b1;
    eng_top_derr_addr = rd_addr;
    if (poke) begin
      frame_start = 1'b1;
      mb_w = 10'd7;
      mb_h = 10'd7;
    end
    @(negedge clk);
    eng_top_derr_en = 1'b0;
    frame_start = 1'b0;
    check({nm, "_top"}, 64'(eng_top_derr), 64'(exp_top));
    repeat (29) @(negedge clk);
    check({nm, "_ov_busy"}, 64'(out_valid), 64'd0);
    eng_done = 1'b1;
    eng_derr = derr;
    @(negedge clk);
    eng_done = 1'b0;
    check({nm, "_ov_store"}, 64'(out_valid), 64'd0);
    if (bp > 0) out_ready = 1'b0;
    @(negedge clk);
    check({nm, "_ov"}, 64'(out_valid), 64'd1);
    check({nm, "_out_x"}, 64'(out_x), 64'(ex));
    check({nm, "_out_y"}, 64'(out_y), 64'(ey));
    check({nm, "_out_last"}, 64'(out_last), 64'(exp_last));
    for (int i = 0; i < bp; i++) begin
      @(negedge clk);
      check({nm, "_bp_ov"}, 64'(out_valid), 64'd1);
      check({nm, "_bp_req"}, 64'(in_req), 64'd0);
      check({nm, "_bp_start"}, 64'(eng_start), 64'd0);
      check({nm, "_bp_x"}, 64'(out_x), 64'(ex));
      check({nm, "_bp_y"}, 64'(out_y), 64'(ey));
      check({nm, "_bp_last"}, 64'(out_last), 64'(exp_last));
    end
    out_ready = 1'b1;
  endtask

  task automatic begin_frame(input string nm, input logic [AW-1:0] w, input logic [AW-1:0] h);
    mb_w = w;
    mb_h = h;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check({nm, "_req"}, 64'(in_req), 64'd1);
    check({nm, "_busy"}, 64'(busy), 64'd1);
  endtask

  task automatic end_frame(input string nm);
    @(negedge clk);
    check({nm, "_done"}, 64'(frame_done), 64'd1);
    check({nm, "_busy_off"}, 64'(busy), 64'd0);
    check({nm, "_idle"}, 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    check({nm, "_done_pulse"}, 64'(frame_done), 64'd0);
  endtask

  task automatic check_all_zero(input string nm);
    check({nm, "_busy"}, 64'(busy), 64'd0);
    check({nm, "_frame_done"}, 64'(frame_done), 64'd0);
    check({nm, "_in_req"}, 64'(in_req), 64'd0);
    check({nm, "_eng_start"}, 64'(eng_start), 64'd0);
    check({nm, "_out_valid"}, 64'(out_valid), 64'd0);
    check({nm, "_out_last"}, 64'(out_last), 64'd0);
    check({nm, "_eng_x"}, 64'(eng_x), 64'd0);
    check({nm, "_eng_y"}, 64'(eng_y), 64'd0);
    check({nm, "_out_x"}, 64'(out_x), 64'd0);
    check({nm, "_out_y"}, 64'(out_y), 64'd0);
    check({nm, "_left"}, 64'(eng_left_derr), 64'd0);
    check({nm, "_top"}, 64'(eng_top_derr), 64'd0);
    check({nm, "_state"}, 64'(dbg_state), 64'(S_IDLE));
  endtask

  // directed sequence
  initial begin
    logic [47:0] ta [6];
    logic [47:0] tb0;
    logic [47:0] tb1;
    logic [47:0] tc0;
    int s0;
    int d0;

    ta[0] = pk(5, -3, 7, 0, 0, -7);
    ta[1] = pk(10, 20, -8, 1, 2, 3);
    ta[2] = pk(-1, -2, 100, 4, 5, 6);
    ta[3] = pk(9, 8, -128, 127, -1, 1);
    ta[4] = pk(2, -5, -100, -3, 3, 40);
    ta[5] = pk(0, 1, 2, -50, 60, -70);
    tb0 = pk(33, -44, 55, -66, 77, -88);
    tb1 = pk(1, 1, 1, 1, 1, 1);
    tc0 = pk(12, 0, -20, 6, 0, 9);

    rst = 1'b1;
    frame_start = 1'b0;
    mb_w = '0;
    mb_h = '0;
    in_valid = 1'b1;
    eng_done = 1'b0;
    eng_derr = '0;
    eng_top_derr_en = 1'b0;
    eng_top_derr_addr = '0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst = 1'b0;
    @(negedge clk);
    check("post_reset_state", 64'(dbg_state), 64'(S_IDLE));

    // frame A: 3x2, no stalls
    s0 = start_cnt;
    d0 = done_cnt;
    begin_frame("fa", 10'd3, 10'd2);
    run_mb("a00", 1, 10'd0, 10'd0, ta[0], 32'd0, 10'd0, 32'd0, 1'b0, 0, 1'b0);
    run_mb("a10", 2, 10'd1, 10'd0, ta[1], DERR_EN ? 32'hFA00_0505 : 32'd0,
           10'd1, 32'd0, 1'b0, 0, 1'b0);
    run_mb("a20", 2, 10'd2, 10'd0, ta[2], left_model(ta[1]), 10'd2, 32'd0, 1'b0, 0, 1'b0);
    run_mb("a01", 2, 10'd0, 10'd1, ta[3], 32'd0, 10'd0,
           DERR_EN ? 32'hFF00_02FD : 32'd0, 1'b0, 0, 1'b0);
    run_mb("a11", 2, 10'd1, 10'd1, ta[4], left_model(ta[3]), 10'd1,
           top_model(ta[1]), 1'b0, 0, 1'b0);
    run_mb("a21", 2, 10'd2, 10'd1, ta[5], left_model(ta[4]), 10'd2,
           top_model(ta[2]), 1'b1, 0, 1'b0);
    end_frame("fa");
    check("fa_start_count", 64'(start_cnt - s0), 64'd6);
    check("fa_done_count", 64'(done_cnt - d0), 64'd1);

    // frame B: 2x1, stale RAM masked on row 0, stall, ignored frame_start
    s0 = start_cnt;
    begin_frame("fb", 10'd2, 10'd1);
    run_mb("b00", 1, 10'd0, 10'd0, tb0, 32'd0, 10'd1, 32'd0, 1'b0, 20, 1'b1);
    run_mb("b10", 2, 10'd1, 10'd0, tb1, left_model(tb0), 10'd1, 32'd0, 1'b1, 0, 1'b0);
    end_frame("fb");
    check("fb_start_count", 64'(start_cnt - s0), 64'd2);

    // frame C: reset while the engine is busy on (1,0)
    begin_frame("fc", 10'd2, 10'd2);
    run_mb("c00", 1, 10'd0, 10'd0, tc0, 32'd0, 10'd0, 32'd0, 1'b0, 0, 1'b0);
    repeat (2) @(negedge clk);
    check("c10_start", 64'(eng_start), 64'd1);
    check("c10_eng_x", 64'(eng_x), 64'd1);
    @(negedge clk);
    check("c10_left", 64'(eng_left_derr), 64'(left_model(tc0)));
    check("c10_state", 64'(dbg_state), 64'(S_BUSY));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_all_zero("midrst");

    // empty frame after reset
    s0 = start_cnt;
    mb_w = 10'd0;
    mb_h = 10'd5;
    frame_start = 1'b1;
    @(negedge clk);
    frame_start = 1'b0;
    check("empty_done", 64'(frame_done), 64'd1);
    check("empty_busy", 64'(busy), 64'd0);
    check("empty_req", 64'(in_req), 64'd0);
    check("empty_state", 64'(dbg_state), 64'(S_IDLE));
    @(negedge clk);
    check("empty_done_pulse", 64'(frame_done), 64'd0);
    repeat (5) @(negedge clk);
    check("empty_no_start", 64'(start_cnt - s0), 64'd0);
    check("empty_busy_low", 64'(busy), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uv_recon_sched.md
# uv_recon_sched

Macroblock scheduler for the chroma reconstruction engine. Walks a frame in raster order, fetches each macroblock's U/V source and prediction through a request/valid handshake, and pulses the engine with the macroblock position. It owns the left and top diffusion-error storage that the engine reads and updates, and hands each finished macroblock downstream under valid/ready backpressure.

## Interface
- MAX_MBW, 1024: top-error RAM depth; must be at least the maximum macroblocks per row.
- AW, 10: macroblock coordinate width.
- clk  in  1  clock; all logic rising-edge.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that starts a frame; ignored while busy.
- mb_w, mb_h  in  AW each  frame size in macroblocks; sampled on an accepted frame_start.
- busy  out  1  high from the accepted frame_start until frame_done.
- frame_done  out  1  one-cycle pulse after the last macroblock is accepted downstream.
- in_req  out  1  request for source/prediction data of (eng_x, eng_y).
- in_valid  in  1  data is present on the engine inputs; held until the request drops.
- eng_start  out  1  one-cycle engine start.
- eng_x, eng_y  out  AW each  current macroblock position.
- eng_done  in  1  one-cycle engine completion pulse.
- eng_derr  in  48  engine errors; byte e[c][k] = eng_derr[24c+8k +: 8], signed.
- eng_left_derr  out  32  left errors; byte l[c][j] at [16c+8j +: 8].
- eng_top_derr  out  32  top errors, registered RAM output; byte t[c][j] at [16c+8j +: 8].
- eng_top_derr_en, eng_top_derr_addr  in  1, AW  engine top-error read port.
- out_valid  out  1  engine outputs for (out_x, out_y) are stable and valid.
- out_ready  in  1  downstream accept.
- out_x, out_y  out  AW each  position of the presented macroblock.
- out_last  out  1  presented macroblock is the last one in the frame.

## Operation
- States:
  - IDLE: accepted frame_start latches mb_w/mb_h, sets x=y=0, clears the left errors, goes to REQ.
  - REQ: in_req=1; in_valid -> START.
  - START: eng_start=1 for exactly one cycle; in_req drops -> BUSY.
  - BUSY: wait for eng_done -> STORE.
  - STORE: one cycle; update the error storage -> OUT.
  - OUT: out_valid=1; out_valid && out_ready -> advance position, then REQ, or IDLE with frame_done.
- eng_done outside BUSY is ignored.
- The next eng_start never occurs before the current macroblock is accepted. The engine outputs stay stable until its next start, so no output buffering is needed.
- Error update in STORE, for c in 0..1, with signed 8-bit wrapping arithmetic:
  - l[c][0] = e[c][0]
  - l[c][1] = (3*e[c][2]) >>> 2, computed at 10 bits, arithmetic shift, truncated to 8 bits
  - top[x] bytes t[c][0] = e[c][1] and t[c][1] = e[c][2] − l[c][1], written to RAM address x
- Advance:
  - x+1 < mb_w: x++.
  - Otherwise x=0 and y++, and the left errors are cleared to 0.
  - Last macroblock (x=mb_w−1, y=mb_h−1): out_last=1; acceptance returns to IDLE and pulses frame_done.
- Top-error read:
  - When y==0, eng_top_derr reads 0 regardless of RAM contents; the RAM is never bulk-cleared.
  - A read and a STORE write to the same address in the same cycle return the old data. The engine reads only before its done pulse, so this case does not arise in normal operation.
- mb_w==0 or mb_h==0: no macroblock is issued; frame_done pulses 1 cycle after frame_start and busy stays 0.

## Timing
- Reset values: busy, frame_done, in_req, eng_start, out_valid, out_last = 0. eng_x, eng_y, out_x, out_y, eng_left_derr, eng_top_derr = 0. State = IDLE.
- in_valid seen in REQ -> eng_start the next cycle.
- eng_done -> STORE the next cycle -> out_valid the cycle after (2-cycle latency).
- Accept -> in_req for the next macroblock the following cycle.
- eng_top_derr is valid 1 cycle after eng_top_derr_en.
- Per-macroblock overhead beyond the engine is 4 cycles when in_valid and out_ready are held high.
- Reset mid-frame returns to IDLE within 1 cycle and drops all outputs. RAM contents are left stale; this is safe because of row-0 masking and because each column is written before it is read.

## Configuration
- UV_SCHED_DERR_EN defined: error storage and RAM exist as described.
- UV_SCHED_DERR_EN undefined: no RAM and no left registers; eng_left_derr and eng_top_derr are tied to 0; STORE still costs one cycle, so timing is identical.

## Structure
- Package uv_sched_pkg holds:
  - the state enum
  - the error-byte index constants and the derr/left/top field-offset functions
- Sub-module uv_derr_ram: simple dual-port, MAX_MBW × 32, registered read, write-first disabled.

## Test plan
- mb_w=3, mb_h=2 with in_valid and out_ready tied high and the engine model's done 32 cycles after start:
  - 6 starts in order (0,0),(1,0),(2,0),(0,1),(1,1),(2,1)
  - out_last only on (2,1)
  - frame_done once
- e[0]=(5,−3,7) -> l[0]=(5,5), top t[0]=(−3,2). e[1]=(0,0,−7) -> l[1]=(0,−6), t[1]=(0,−1).
- Row-0 masking: preload RAM address 1 with 0xFFFFFFFF; a read at y=0 returns 0. At y=1, address 1 returns the value stored for (1,0).
- Row wrap: the macroblock at (0,1) receives eng_left_derr=0 even though (2,0) stored nonzero errors.
- Backpressure: hold out_ready low for 20 cycles -> out_valid held, no new in_req or eng_start, and outputs unchanged.
- Reset asserted during BUSY, then frame_start with mb_w=0 -> IDLE with all outputs 0; frame_done pulses 1 cycle later with no eng_start.
